lc3_fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the LC-3 control unit.
- Owns the PC and issues 16-bit reads to instruction memory over a req/ack handshake.
- Latches the fetched word and presents it to the control unit as `instr`.
- Applies PC redirects (sequential, PC-relative, register) when the control unit retires an instruction.

---
 rtl/lc3_pkg.sv | 18 +
 rtl/lc3_pc_next.sv | 25 ++
 rtl/lc3_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_lc3_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 fetch definitions: word width, pc_sel encodings and fetch FSM states.
package lc3_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] PC_1      = 2'b00;
  localparam logic [1:0] PC_OFFSET = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StErr
  } fetch_state_e;

endpackage

// File: rtl/lc3_pc_next.sv
// Combinational next-PC select: sequential, PC-relative or register target.
module lc3_pc_next
  import lc3_pkg::*;
(
  input  logic [WORD_W-1:0] pc_i,
  input  logic              pc_write_i,
  input  logic [1:0]        pc_sel_i,
  input  logic [WORD_W-1:0] pc_offset_i,
  input  logic [WORD_W-1:0] reg_target_i,
  output logic [WORD_W-1:0] pc_next_o
);

  always_comb begin
    pc_next_o = pc_i;
    if (pc_write_i) begin
      unique case (pc_sel_i)
        PC_1:      pc_next_o = pc_i;
        PC_OFFSET: pc_next_o = pc_i + pc_offset_i;
        PC_REG:    pc_next_o = reg_target_i;
        default:   pc_next_o = pc_i;
      endcase
    end
  end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch stage: owns the PC, fetches over req/ack, applies redirects on retire.
// Define LC3_FETCH_STALL_CNT_EN to build the saturating stall_cycles counter.
module lc3_fetch_unit
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h3000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_done,
  input  logic        pc_write,
  input  logic [1:0]  pc_sel,
  input  logic [15:0] pc_offset,
  input  logic [15:0] reg_target,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic        fetch_err,
  output logic [15:0] stall_cycles
);

  localparam logic [7:0] AckTimeout = 8'(ACK_TIMEOUT);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_redirect;
  logic              mem_req_q, mem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;

  lc3_pc_next u_pc_next (
    .pc_i         (pc_q),
    .pc_write_i   (pc_write),
    .pc_sel_i     (pc_sel),
    .pc_offset_i  (pc_offset),
    .reg_target_i (reg_target),
    .pc_next_o    (pc_redirect)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    mem_req_d     = mem_req_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    wait_cnt_d    = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        state_d    = StReq;
        mem_req_d  = 1'b1;
        wait_cnt_d = 8'd0;
      end
      // An ack in the first request cycle is accepted exactly like a later one.
      StReq, StWait: begin
        if (mem_ack) begin
          instr_d       = mem_rdata;
          pc_d          = pc_q + 16'd1;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = StHold;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          state_d    = StWait;
          if (wait_cnt_q + 8'd1 >= AckTimeout) begin
            fetch_err_d = 1'b1;
            mem_req_d   = 1'b0;
            state_d     = StErr;
          end
        end
      end
      StHold: begin
        if (instr_done) begin
          instr_valid_d = 1'b0;
          pc_d          = pc_redirect;
          mem_req_d     = 1'b1;
          wait_cnt_d    = 8'd0;
          state_d       = StReq;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      wait_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

`ifdef LC3_FETCH_STALL_CNT_EN
  logic [WORD_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StReq || state_q == StWait) && !mem_ack && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Scoreboard bench for lc3_fetch_unit: stimulus pushes expected requests/fetches, a monitor checks.
module tb_lc3_fetch_unit;

  typedef struct {
    logic [15:0] word;
    logic [15:0] pc;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_done = 1'b0;
  logic        pc_write = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [15:0] pc_offset = '0;
  logic [15:0] reg_target = '0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic        fetch_err;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] exp_pc = 16'h3000;
  logic [15:0] last_word = 16'h0000;
  int          model_stall = 0;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_req_q [$];
  fetch_t      exp_fetch_q [$];

  // Monitor state
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [15:0] cur_addr = '0;

  lc3_fetch_unit #(
    .RESET_PC    (16'h3000),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_done   (instr_done),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .pc_offset    (pc_offset),
    .reg_target   (reg_target),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .fetch_err    (fetch_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  function automatic logic [15:0] exp_stall();
`ifdef LC3_FETCH_STALL_CNT_EN
    return (model_stall > 65535) ? 16'hFFFF : 16'(model_stall);
`else
    return 16'h0000;
`endif
  endfunction

  // Monitor: every new request must target the next queued address, and every newly
  // valid instruction must match the queued word and post-increment PC.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req === 1'b1 && prev_req !== 1'b1) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_req", mem_addr, 16'hxxxx);
        end else begin
          cur_addr = exp_req_q.pop_front();
          check("req_addr", mem_addr, cur_addr);
        end
      end else if (mem_req === 1'b1) begin
        check("req_addr_stable", mem_addr, cur_addr);
      end
      if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (exp_fetch_q.size() == 0) begin
          check("unexpected_fetch", instr, 16'hxxxx);
        end else begin
          fetch_t f;
          f = exp_fetch_q.pop_front();
          check("fetch_instr", instr, f.word);
          check("fetch_pc", pc, f.pc);
        end
      end
    end
    prev_req   = mem_req;
    prev_valid = instr_valid;
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    exp_pc      = 16'h3000;
    model_stall = 0;
    last_word   = 16'h0000;
    check("rst_pc", pc, 16'h3000);
    check("rst_mem_req", {15'b0, mem_req}, 16'd0);
    check("rst_instr_valid", {15'b0, instr_valid}, 16'd0);
    check("rst_fetch_err", {15'b0, fetch_err}, 16'd0);
    check("rst_instr", instr, 16'h0000);
    check("rst_stall", stall_cycles, 16'h0000);
    exp_req_q.push_back(exp_pc);
    reset = 1'b0;
    tick();
    check("req_after_dead_cycle", {15'b0, mem_req}, 16'd1);
  endtask

  // Acks the pending request after `delay` non-ack cycles; stray retires meanwhile are ignored.
  task automatic do_fetch(input int delay);
    int n = 0;
    logic [15:0] w;
    while (mem_req !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    check("req_seen", {15'b0, mem_req}, 16'd1);
    if (mem_req !== 1'b1) return;
    for (int i = 0; i < delay; i++) begin
      instr_done = 1'($urandom);
      pc_write   = 1'b1;
      pc_sel     = 2'b10;
      reg_target = 16'($urandom);
      tick();
    end
    instr_done = 1'b0;
    pc_write   = 1'b0;
    w = word_at(exp_pc);
    last_word = w;
    exp_fetch_q.push_back('{word: w, pc: exp_pc + 16'd1});
    exp_pc = exp_pc + 16'd1;
    model_stall += delay;
    mem_ack   = 1'b1;
    mem_rdata = w;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    check("valid_after_ack", {15'b0, instr_valid}, 16'd1);
    check("stall", stall_cycles, exp_stall());
  endtask

  task automatic retire(input logic pw, input logic [1:0] sel, input logic [15:0] off,
                        input logic [15:0] tgt, input int pre);
    for (int i = 0; i < pre; i++) begin
      pc_write   = 1'b1;
      pc_sel     = 2'($urandom_range(1, 2));
      pc_offset  = 16'($urandom);
      reg_target = 16'($urandom);
      tick();
      check("hold_valid", {15'b0, instr_valid}, 16'd1);
    end
    pc_write   = pw;
    pc_sel     = sel;
    pc_offset  = off;
    reg_target = tgt;
    instr_done = 1'b1;
    if (pw && sel == 2'b01) exp_pc = exp_pc + off;
    else if (pw && sel == 2'b10) exp_pc = tgt;
    exp_req_q.push_back(exp_pc);
    tick();
    instr_done = 1'b0;
    pc_write   = 1'b0;
    check("retire_valid", {15'b0, instr_valid}, 16'd0);
    check("instr_hold", instr, last_word);
  endtask

  task automatic spurious_ack_hold();
    mem_ack   = 1'b1;
    mem_rdata = ~last_word;
    tick();
    mem_ack   = 1'b0;
    check("hold_ack_instr", instr, last_word);
    check("hold_ack_pc", pc, exp_pc);
    check("hold_ack_req", {15'b0, mem_req}, 16'd0);
  endtask

  initial begin
    mem[16'h3000] = 16'h1234;
    do_reset();

    do_fetch(0);
    check("first_instr", instr, 16'h1234);
    check("first_pc", pc, 16'h3001);
    retire(1'b1, 2'b01, 16'hFFFE, 16'h0000, 0);
    do_fetch(0);
    retire(1'b1, 2'b10, 16'h0000, 16'h4000, 1);
    do_fetch(0);
    retire(1'b0, 2'b01, 16'h0100, 16'h0000, 0);
    do_fetch(3);
    check("stall_after_delay3", stall_cycles, exp_stall());
    retire(1'b1, 2'b11, 16'h0040, 16'h5555, 0);

    for (int k = 0; k < 40; k++) begin
      do_fetch(int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) spurious_ack_hold();
      retire(1'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 2)));
    end

    do_fetch(1);
    retire(1'b1, 2'b10, 16'h0000, 16'hFFFF, 0);
    do_fetch(0);
    check("wrap_pc", pc, 16'h0000);
    spurious_ack_hold();
    retire(1'b0, 2'b00, 16'h0000, 16'h0000, 0);

    // Timeout: no ack for ACK_TIMEOUT request cycles
    for (int i = 0; i < 14; i++) tick();
    check("pre_timeout_err", {15'b0, fetch_err}, 16'd0);
    check("pre_timeout_req", {15'b0, mem_req}, 16'd1);
    tick();
    model_stall += 15;
    check("timeout_err", {15'b0, fetch_err}, 16'd1);
    check("timeout_req", {15'b0, mem_req}, 16'd0);
    check("timeout_stall", stall_cycles, exp_stall());
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("err_instr", instr, last_word);
    check("err_req", {15'b0, mem_req}, 16'd0);
    check("err_sticky", {15'b0, fetch_err}, 16'd1);
    check("err_valid", {15'b0, instr_valid}, 16'd0);

    do_reset();
    do_fetch(2);
    check("post_err_instr", instr, 16'h1234);
    retire(1'b0, 2'b00, 16'h0000, 16'h0000, 0);

    // Reset during a waiting fetch, with the stale ack landing one cycle later
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    exp_pc      = 16'h3000;
    model_stall = 0;
    last_word   = 16'h0000;
    check("midrst_pc", pc, 16'h3000);
    check("midrst_valid", {15'b0, instr_valid}, 16'd0);
    check("midrst_instr", instr, 16'h0000);
    check("midrst_req", {15'b0, mem_req}, 16'd0);
    check("midrst_stall", stall_cycles, 16'h0000);
    exp_req_q.push_back(16'h3000);
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("late_ack_instr", instr, 16'h0000);
    check("late_ack_valid", {15'b0, instr_valid}, 16'd0);
    check("late_ack_req", {15'b0, mem_req}, 16'd1);
    do_fetch(1);
    check("midrst_refetch", instr, 16'h1234);

    for (int i = 0; i < 3; i++) tick();
    check("req_queue_drained", 16'(exp_req_q.size()), 16'd0);
    check("fetch_queue_drained", 16'(exp_fetch_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
